// File: rtl/nn_seq_pkg.sv
// ============================================================================
// Module      : nn_seq_pkg
// Description : Shared types and constants for the network inference
//               sequencer. Holds the sequencer state encoding, the default
//               counter/watchdog sizes, and a log2 helper that never yields 0.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package nn_seq_pkg;

    // Sequencer states. Each handshake phase has a request state (req high,
    // waiting for ack rise) and a release state (req low, waiting for ack fall).
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FILL      = 3'd1,
        S_FILL_REL  = 3'd2,
        S_LAYER     = 3'd3,
        S_LAYER_REL = 3'd4,
        S_DRAIN     = 3'd5,
        S_DRAIN_REL = 3'd6,
        S_DONE      = 3'd7
    } nn_seq_state_t;

    localparam int C_DEF_CNT_W   = 16;
    localparam int C_DEF_TIMEOUT = 1024;

    // Width of an index over n items, at least one bit so a single-layer
    // network still gets a legal cur_layer port.
    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/nn_seq_hs_phase.sv
// ============================================================================
// Module      : nn_seq_hs_phase
// Description : Generic four-phase req/ack stage. Shared by the fill, layer
//               and drain phases; the caller muxes the active channel's ack
//               in and routes req back out to that channel.
// Ports       : i_go    - caller is in the request half of the phase
//               i_rel   - caller is in the release half of the phase
//               i_ack   - ack of the channel currently selected
//               o_req   - request to the selected channel
//               o_acked - ack seen high while requesting (advance to release)
//               o_fin   - ack seen low while releasing (phase complete)
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module nn_seq_hs_phase (
    input  logic i_go,
    input  logic i_rel,
    input  logic i_ack,
    output logic o_req,
    output logic o_acked,
    output logic o_fin
);

    // req is a pure decode of the caller's registered state, so it can only
    // rise again after the release half has observed the ack low.
    assign o_req   = i_go;
    assign o_acked = i_go & i_ack;
    assign o_fin   = i_rel & ~i_ack;

endmodule

`default_nettype wire

// File: rtl/nn_network_sequencer.sv
// ============================================================================
// Module      : nn_network_sequencer
// Description : Scheduler for one inference pass: input fill, each layer in
//               order, then output drain, every phase as a four-phase
//               req/ack handshake. Counts completed inferences and latches
//               protocol errors.
// Ports       : clk        - system clock, rising edge
//               rst        - asynchronous active-low reset
//               start      - request an inference (sampled only in IDLE)
//               busy       - high in every state except IDLE
//               done       - one-cycle pulse on inference completion
//               fill_req / fill_ack   - input channel handshake
//               layer_req / layer_ack - one-hot per-layer handshake
//               drain_req / drain_ack - output channel handshake
//               cur_layer  - active or last-run layer index
//               inf_count  - completed inferences (wrapping)
//               err        - sticky protocol error, cleared on accepted start
//               timeout    - sticky watchdog flag
// Options     : SEQ_TIMEOUT_EN - enables the wait-state watchdog; when not
//               defined, timeout is tied low and waits are unbounded.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module nn_network_sequencer
    import nn_seq_pkg::*;
#(
    parameter int N_LAYERS = 2,
    parameter int CNT_W    = C_DEF_CNT_W,
    parameter int TIMEOUT  = C_DEF_TIMEOUT,
    localparam int LW      = clog2_min1(N_LAYERS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                fill_req,
    input  logic                fill_ack,
    output logic [N_LAYERS-1:0] layer_req,
    input  logic [N_LAYERS-1:0] layer_ack,
    output logic                drain_req,
    input  logic                drain_ack,
    output logic [LW-1:0]       cur_layer,
    output logic [CNT_W-1:0]    inf_count,
    output logic                err,
    output logic                timeout
);

    nn_seq_state_t       r_state;
    nn_seq_state_t       w_next;
    logic [LW-1:0]       r_cur_layer;
    logic [CNT_W-1:0]    r_inf_count;
    logic                r_err;

    logic [N_LAYERS-1:0] w_cur_onehot;
    logic                w_in_fill;
    logic                w_in_layer;
    logic                w_in_drain;
    logic                w_go;
    logic                w_rel;
    logic                w_ack_mux;
    logic                w_req;
    logic                w_acked;
    logic                w_fin;
    logic                w_last_layer;
    logic                w_accept;
    logic                w_err_set;
    logic                w_tmo_fire;

    assign w_cur_onehot = N_LAYERS'(1) << r_cur_layer;
    assign w_last_layer = (r_cur_layer == LW'(N_LAYERS - 1));
    assign w_accept     = (r_state == S_IDLE) && start;

    assign w_in_fill  = (r_state == S_FILL)  || (r_state == S_FILL_REL);
    assign w_in_layer = (r_state == S_LAYER) || (r_state == S_LAYER_REL);
    assign w_in_drain = (r_state == S_DRAIN) || (r_state == S_DRAIN_REL);
    assign w_go       = (r_state == S_FILL)  || (r_state == S_LAYER) ||
                        (r_state == S_DRAIN);
    assign w_rel      = (r_state == S_FILL_REL)  || (r_state == S_LAYER_REL) ||
                        (r_state == S_DRAIN_REL);

    // Select the ack of whichever channel owns the current phase.
    always_comb begin
        w_ack_mux = 1'b0;
        if (w_in_fill) begin
            w_ack_mux = fill_ack;
        end else if (w_in_layer) begin
            w_ack_mux = layer_ack[r_cur_layer];
        end else if (w_in_drain) begin
            w_ack_mux = drain_ack;
        end
    end

    nn_seq_hs_phase u_hs_phase (
        .i_go    (w_go),
        .i_rel   (w_rel),
        .i_ack   (w_ack_mux),
        .o_req   (w_req),
        .o_acked (w_acked),
        .o_fin   (w_fin)
    );

    // Acks from channels that do not own the current phase are protocol
    // errors. The sequence keeps running; the flag just records it.
    assign w_err_set = ((r_state != S_IDLE) && |(layer_ack & ~w_cur_onehot)) ||
                       (fill_ack  && !w_in_fill) ||
                       (drain_ack && !w_in_drain);

`ifdef SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT) + 1;

    logic [TW-1:0] r_wait_cnt;
    logic          r_timeout;

    // Fires on the TIMEOUT-th cycle spent in one wait state; a handshake
    // completing in that same cycle takes priority.
    assign w_tmo_fire = (w_go || w_rel) && !(w_acked || w_fin) &&
                        (r_wait_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            if (w_next != r_state) begin
                r_wait_cnt <= '0;
            end else if (r_wait_cnt != {TW{1'b1}}) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (w_tmo_fire) begin
                r_timeout <= 1'b1;
            end else if (w_accept) begin
                r_timeout <= 1'b0;
            end
        end
    end

    assign timeout = r_timeout;
`else
    logic w_unused_timeout;

    assign w_tmo_fire       = 1'b0;
    assign w_unused_timeout = (TIMEOUT != 0);
    assign timeout          = 1'b0;
`endif

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (start)   w_next = S_FILL;
            S_FILL:      if (w_acked) w_next = S_FILL_REL;
            S_FILL_REL:  if (w_fin)   w_next = S_LAYER;
            S_LAYER:     if (w_acked) w_next = S_LAYER_REL;
            S_LAYER_REL: if (w_fin)   w_next = w_last_layer ? S_DRAIN : S_LAYER;
            S_DRAIN:     if (w_acked) w_next = S_DRAIN_REL;
            S_DRAIN_REL: if (w_fin)   w_next = S_DONE;
            S_DONE:                   w_next = S_IDLE;
            default:                  w_next = S_IDLE;
        endcase
        if (w_tmo_fire) begin
            w_next = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cur_layer <= '0;
            r_inf_count <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= w_err_set | (r_err & ~w_accept);
            if (w_accept) begin
                r_cur_layer <= '0;
            end else if ((r_state == S_LAYER_REL) && w_fin && !w_last_layer) begin
                r_cur_layer <= r_cur_layer + 1'b1;
            end
            // Count on entry to DONE so the count is current while done is high.
            if (w_next == S_DONE) begin
                r_inf_count <= r_inf_count + 1'b1;
            end
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign fill_req  = w_req & w_in_fill;
    assign drain_req = w_req & w_in_drain;
    assign layer_req = (w_req & w_in_layer) ? w_cur_onehot : '0;
    assign cur_layer = r_cur_layer;
    assign inf_count = r_inf_count;
    assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_nn_network_sequencer.sv
// ============================================================================
// Module      : tb_nn_network_sequencer
// Description : Directed self-checking bench for nn_network_sequencer with
//               programmable-delay ack responders and a four-phase monitor.
//               With SEQ_TIMEOUT_EN defined it also exercises the watchdog.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_nn_network_sequencer;

    localparam int N_LAYERS = 2;
    localparam int CNT_W    = 16;
`ifdef SEQ_TIMEOUT_EN
    localparam int TIMEOUT  = 16;
`else
    localparam int TIMEOUT  = 1024;
`endif

    logic                clk   = 1'b0;
    logic                rst   = 1'b0;
    logic                start = 1'b0;
    wire                 busy;
    wire                 done;
    wire                 fill_req;
    wire                 fill_ack;
    wire [N_LAYERS-1:0]  layer_req;
    wire [N_LAYERS-1:0]  layer_ack;
    wire                 drain_req;
    wire                 drain_ack;
    wire [0:0]           cur_layer;
    wire [CNT_W-1:0]     inf_count;
    wire                 err;
    wire                 timeout;

    int n_checks = 0;
    int n_errors = 0;

    nn_network_sequencer #(
        .N_LAYERS (N_LAYERS),
        .CNT_W    (CNT_W),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .fill_req  (fill_req),
        .fill_ack  (fill_ack),
        .layer_req (layer_req),
        .layer_ack (layer_ack),
        .drain_req (drain_req),
        .drain_ack (drain_ack),
        .cur_layer (cur_layer),
        .inf_count (inf_count),
        .err       (err),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Ack responders: delay 0 means ack follows req combinationally;
    // delay d raises ack d edges late. Ack always drops with req.
    // ------------------------------------------------------------------
    int                fill_dly  = 0;
    int                drain_dly = 0;
    int                layer_dly [N_LAYERS];
    logic              fill_inj  = 1'b0;
    logic              drain_inj = 1'b0;
    logic [N_LAYERS-1:0] layer_inj = '0;

    logic fill_r  = 1'b0;
    int   fill_c  = 0;
    logic drain_r = 1'b0;
    int   drain_c = 0;

    always @(posedge clk) begin
        if (!fill_req) begin
            fill_r <= 1'b0;
            fill_c <= 0;
        end else if (fill_c >= fill_dly - 1) begin
            fill_r <= 1'b1;
        end else begin
            fill_c <= fill_c + 1;
        end
    end

    always @(posedge clk) begin
        if (!drain_req) begin
            drain_r <= 1'b0;
            drain_c <= 0;
        end else if (drain_c >= drain_dly - 1) begin
            drain_r <= 1'b1;
        end else begin
            drain_c <= drain_c + 1;
        end
    end

    assign fill_ack  = (fill_req  & ((fill_dly  == 0) | fill_r))  | fill_inj;
    assign drain_ack = (drain_req & ((drain_dly == 0) | drain_r)) | drain_inj;

    generate
        for (genvar gi = 0; gi < N_LAYERS; gi++) begin : g_layer_resp
            logic r_ack = 1'b0;
            int   cnt   = 0;
            always @(posedge clk) begin
                if (!layer_req[gi]) begin
                    r_ack <= 1'b0;
                    cnt   <= 0;
                end else if (cnt >= layer_dly[gi] - 1) begin
                    r_ack <= 1'b1;
                end else begin
                    cnt <= cnt + 1;
                end
            end
            assign layer_ack[gi] = (layer_req[gi] & ((layer_dly[gi] == 0) | r_ack)) |
                                   layer_inj[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Four-phase monitor: a req may only fall after its ack was seen high,
    // and may only rise after its ack was seen low.
    // ------------------------------------------------------------------
    logic [N_LAYERS+1:0] p_req  = '0;
    logic [N_LAYERS+1:0] p_ack  = '0;
    logic                mon_en = 1'b1;
    int                  viol   = 0;
    wire  [N_LAYERS+1:0] c_req  = {drain_req, layer_req, fill_req};
    wire  [N_LAYERS+1:0] c_ack  = {drain_ack, layer_ack, fill_ack};

    always @(posedge clk) begin
        #1;
        if (mon_en && |((p_req & ~c_req & ~p_ack) | (~p_req & c_req & p_ack))) begin
            viol <= viol + 1;
        end
        p_req <= c_req;
        p_ack <= c_ack;
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [N_LAYERS-1:0] seq0;
    logic [N_LAYERS-1:0] seq1;
    int                  seq_n;

    // Pulse start for the sampling edge, then count edges until done is seen.
    // Leaves the DUT back in IDLE one edge after done.
    task automatic run_inf(output int edges);
        logic [N_LAYERS-1:0] last;
        seq_n = 0;
        seq0  = '0;
        seq1  = '0;
        last  = '0;
        start = 1'b1;
        step();
        start = 1'b0;
        edges = 0;
        while (done !== 1'b1 && edges < 300) begin
            step();
            edges++;
            if (layer_req != '0 && layer_req != last) begin
                if (seq_n == 0) seq0 = layer_req;
                else if (seq_n == 1) seq1 = layer_req;
                seq_n++;
                last = layer_req;
            end
        end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed still running, expected finished");
        $fatal(1, "bench time limit");
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int edges;
        int dcnt;
        int base;

        for (int i = 0; i < N_LAYERS; i++) layer_dly[i] = 0;

        // Reset state
        #12;
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_done",      32'(done),      32'd0);
        chk("rst_fill_req",  32'(fill_req),  32'd0);
        chk("rst_layer_req", 32'(layer_req), 32'd0);
        chk("rst_drain_req", 32'(drain_req), 32'd0);
        chk("rst_cur_layer", 32'(cur_layer), 32'd0);
        chk("rst_inf_count", 32'(inf_count), 32'd0);
        chk("rst_err",       32'(err),       32'd0);
        chk("rst_timeout",   32'(timeout),   32'd0);
        rst = 1'b1;
        step();
        chk("idle_busy", 32'(busy), 32'd0);

        // 1. Zero-delay acks
        run_inf(edges);
        chk("t1_latency",   32'(edges),     32'd8);
        chk("t1_nlayers",   32'(seq_n),     32'd2);
        chk("t1_layer0",    32'(seq0),      32'b01);
        chk("t1_layer1",    32'(seq1),      32'b10);
        chk("t1_busy",      32'(busy),      32'd0);
        chk("t1_inf_count", 32'(inf_count), 32'd1);
        chk("t1_err",       32'(err),       32'd0);

        // 2. Delayed acks: fill +3, layer1 +5
        fill_dly     = 3;
        layer_dly[1] = 5;
        run_inf(edges);
        fill_dly     = 0;
        layer_dly[1] = 0;
        chk("t2_latency",   32'(edges),     32'd16);
        chk("t2_inf_count", 32'(inf_count), 32'd2);
        chk("t2_handshake", 32'(viol),      32'd0);
        chk("t2_err",       32'(err),       32'd0);

        // 3. Stray layer_ack[1] while layer 0 is requested
        layer_dly[0] = 3;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("t3_cur_layer", 32'(cur_layer), 32'd0);
        chk("t3_layer_req", 32'(layer_req), 32'b01);
        layer_inj = 2'b10;
        step();
        layer_inj = '0;
        chk("t3_err_set", 32'(err), 32'd1);
        edges = 3;
        while (done !== 1'b1 && edges < 300) begin
            step();
            edges++;
        end
        chk("t3_latency",  32'(edges), 32'd11);
        chk("t3_err_held", 32'(err),   32'd1);
        step();
        chk("t3_inf_count", 32'(inf_count), 32'd3);
        layer_dly[0] = 0;
        run_inf(edges);
        chk("t3_err_cleared", 32'(err),       32'd0);
        chk("t3b_inf_count",  32'(inf_count), 32'd4);

        // 4. start held for 30 edges: one inference per IDLE entry
        base  = 32'(inf_count);
        dcnt  = 0;
        start = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (done === 1'b1) dcnt++;
        end
        start = 1'b0;
        chk("t4_done_pulses", 32'(dcnt),      32'd3);
        chk("t4_inf_count",   32'(inf_count), 32'(base + 3));
        step();
        chk("t4_idle", 32'(busy), 32'd0);
        chk("t4_handshake", 32'(viol), 32'd0);

        // 5. Asynchronous reset while layer 1 is requested
        layer_dly[1] = 50;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        chk("t5_cur_layer", 32'(cur_layer), 32'd1);
        chk("t5_layer_req", 32'(layer_req), 32'b10);
        mon_en = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("t5_async_req",  32'(layer_req), 32'd0);
        chk("t5_async_busy", 32'(busy),      32'd0);
        chk("t5_async_cnt",  32'(inf_count), 32'd0);
        chk("t5_async_cur",  32'(cur_layer), 32'd0);
        rst = 1'b1;
        layer_dly[1] = 0;
        step();
        step();
        chk("t5_stay_idle", 32'(busy), 32'd0);
        mon_en = 1'b1;
        run_inf(edges);
        chk("t5_latency",   32'(edges),     32'd8);
        chk("t5_inf_count", 32'(inf_count), 32'd1);

`ifdef SEQ_TIMEOUT_EN
        // 6. Watchdog: drain_ack never rises
        mon_en    = 1'b0;
        drain_dly = 1000;
        dcnt      = 0;
        start     = 1'b1;
        step();
        start = 1'b0;
        edges = 0;
        while (busy === 1'b1 && edges < 100) begin
            step();
            edges++;
            if (done === 1'b1) dcnt++;
        end
        drain_dly = 0;
        chk("t6_exit_edge", 32'(edges),     32'd22);
        chk("t6_busy",      32'(busy),      32'd0);
        chk("t6_timeout",   32'(timeout),   32'd1);
        chk("t6_no_done",   32'(dcnt),      32'd0);
        chk("t6_inf_count", 32'(inf_count), 32'd1);
        step();
        step();
        mon_en = 1'b1;
        run_inf(edges);
        chk("t6_timeout_cleared", 32'(timeout),   32'd0);
        chk("t6b_inf_count",      32'(inf_count), 32'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
